// File: rtl/spu_clk_sequencer.sv
// SPU clock sequencer: PLL lock qualification, core reset release,
// 44.1 kHz sample strobe generation and lock-loss counting.
//
// Ports:
//   clk           33.8688 MHz clock from PLL outclk_0
//   rst_n         asynchronous active-low reset (all flops)
//   pll_locked    PLL locked flag, asynchronous to clk
//   core_rst_n    registered active-low reset to the SPU core
//   sample_ce     one-cycle strobe every DIV clocks while running
//   div_phase     divider count 0..DIV-1, zero while core held
//   lock_loss_cnt saturating count of RUN -> WAIT_LOCK exits
module spu_clk_sequencer #(
  parameter int LOCK_CYCLES = 1024,
  parameter int DIV         = 768,
  parameter int LOSS_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  output logic              core_rst_n,
  output logic              sample_ce,
  output logic [9:0]        div_phase,
  output logic [LOSS_W-1:0] lock_loss_cnt
);

  localparam int LCW =
    (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int DW = $clog2(DIV);

  localparam logic [LCW-1:0] LOCK_LAST =
    LCW'(LOCK_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST =
    DW'(DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_e;

  logic              sync1_q;
  logic              locked_s_q;
  state_e            state_q;
  state_e            state_d;
  logic [LCW-1:0]    lock_cnt_q;
  logic [LCW-1:0]    lock_cnt_d;
  logic [LOSS_W-1:0] loss_q;
  logic [LOSS_W-1:0] loss_d;
  logic              core_rst_q;
  logic              core_rst_d;
  logic [DW-1:0]     div_q;
  logic [DW-1:0]     div_d;

  // Two-flop synchroniser for the asynchronous lock flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_LOCK;
      lock_cnt_q <= '0;
      loss_q     <= '0;
      core_rst_q <= 1'b0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      loss_q     <= loss_d;
      core_rst_q <= core_rst_d;
      div_q      <= div_d;
    end
  end

  // Lock qualification: any low sample of the
  // synchronised flag restarts the whole count.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    loss_d     = loss_q;
    unique case (state_q)
      WAIT_LOCK: begin
        lock_cnt_d = '0;
        if (locked_s_q) begin
          state_d = STABLE;
        end
      end
      STABLE: begin
        if (!locked_s_q) begin
          state_d    = WAIT_LOCK;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d = RUN;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end
      RUN: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          // Saturate: a debug counter must not
          // wrap back to a reassuring zero.
          if (loss_q != '1) begin
            loss_d = loss_q + LOSS_W'(1);
          end
        end
      end
      default: begin
        state_d    = WAIT_LOCK;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Core reset follows the state one edge late.
  assign core_rst_d = (state_q == RUN);

  // Divider runs only while the core is out
  // of reset; it parks at zero otherwise.
  always_comb begin
    div_d = '0;
    if (core_rst_q) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  // Strobe decoded from flops only, so it
  // cannot glitch and drops with async reset.
  assign sample_ce     = core_rst_q &
                         (div_q == DIV_LAST);
  assign core_rst_n    = core_rst_q;
  assign div_phase     = 10'(div_q);
  assign lock_loss_cnt = loss_q;

endmodule
